// File: rtl/rd_check_pkg.sv
// Shared definitions for the AXI read-data checker: softreg map, FSM states, error-type bits.
package rd_check_pkg;

  localparam logic [31:0] ADDR_CTRL   = 32'h60;
  localparam logic [31:0] ADDR_BEATS  = 32'h68;
  localparam logic [31:0] ADDR_BURSTS = 32'h70;
  localparam logic [31:0] ADDR_ERRS   = 32'h78;
  localparam logic [31:0] ADDR_CAP    = 32'h80;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [2:0] ERR_REPL = 3'b001;
  localparam logic [2:0] ERR_RESP = 3'b010;
  localparam logic [2:0] ERR_LAST = 3'b100;

  localparam int unsigned CapW = 43;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rd_check_lane_cmp.sv
// Combinational check that all 32 16-bit lanes of a 512-bit beat equal lane 0.
module rd_check_lane_cmp (
  input  logic [511:0] data,
  output logic         mismatch
);

  always_comb begin
    mismatch = 1'b0;
    for (int i = 1; i < 32; i++) begin
      if (data[i*16 +: 16] != data[15:0]) mismatch = 1'b1;
    end
  end

endmodule

// File: rtl/rd_check.sv
// Passive AXI read-data checker with softreg control/status.
// Define RD_CHECK_ERR_CAPTURE_EN to add the first-error capture register at 0x80.
module rd_check
  import rd_check_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  rid_m,
  input  logic [511:0] rdata_m,
  input  logic [1:0]   rresp_m,
  input  logic         rlast_m,
  input  logic         rvalid_m,
  input  logic         rready_m,
  input  logic         softreg_req_valid,
  input  logic         softreg_req_isWrite,
  input  logic [31:0]  softreg_req_addr,
  input  logic [63:0]  softreg_req_data,
  output logic         softreg_resp_valid,
  output logic [63:0]  softreg_resp_data,
  output logic         chk_done,
  output logic         chk_err
);

  state_e state_q, state_d;

  logic [7:0]  exp_len_q;
  logic [19:0] target_q;
  logic [19:0] eff_target;

  logic        p_valid_q, p_repl_q, p_resp_q, p_last_q;
  logic [7:0]  word_cnt_q;
  logic [19:0] burst_cnt_q;
  logic [47:0] beat_cnt_q;
  logic [15:0] repl_cnt_q, resp_cnt_q, last_cnt_q;

  logic        resp_valid_q;
  logic [63:0] resp_data_q, rd_data, cap_rd;

  logic start, beat, take, repl_mismatch, last_bad;
  logic [2:0] err_type;

  logic unused_bits;
  assign unused_bits = ^softreg_req_data[63:28];

  assign start = softreg_req_valid && softreg_req_isWrite && (softreg_req_addr == ADDR_CTRL);
  assign beat  = rvalid_m && rready_m;
  // A start in the same cycle as a beat wins; that beat is dropped.
  assign take  = beat && (state_q == StRun) && !start;

  rd_check_lane_cmp u_lane_cmp (
    .data     (rdata_m),
    .mismatch (repl_mismatch)
  );

  // word_cnt_q holds the position of the pipelined beat within its burst.
  always_comb begin
    last_bad = p_last_q ? (word_cnt_q != exp_len_q) : (word_cnt_q == exp_len_q);
    err_type = 3'b000;
    if (p_valid_q) begin
      if (p_repl_q) err_type = err_type | ERR_REPL;
      if (p_resp_q) err_type = err_type | ERR_RESP;
      if (last_bad) err_type = err_type | ERR_LAST;
    end
  end

  assign eff_target = (target_q == 20'd0) ? 20'd1 : target_q;

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = StRun;
    end else if ((state_q == StRun) && (burst_cnt_q == eff_target)) begin
      state_d = StDone;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      exp_len_q <= 8'd0;
      target_q  <= 20'd0;
    end else begin
      state_q <= state_d;
      if (start) begin
        exp_len_q <= softreg_req_data[7:0];
        target_q  <= softreg_req_data[27:8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid_q <= 1'b0;
      p_repl_q  <= 1'b0;
      p_resp_q  <= 1'b0;
      p_last_q  <= 1'b0;
    end else if (start) begin
      p_valid_q <= 1'b0;
      p_repl_q  <= 1'b0;
      p_resp_q  <= 1'b0;
      p_last_q  <= 1'b0;
    end else begin
      p_valid_q <= take;
      if (take) begin
        p_repl_q <= repl_mismatch;
        p_resp_q <= (rresp_m != 2'b00);
        p_last_q <= rlast_m;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt_q  <= 8'd0;
      burst_cnt_q <= 20'd0;
      beat_cnt_q  <= 48'd0;
      repl_cnt_q  <= 16'd0;
      resp_cnt_q  <= 16'd0;
      last_cnt_q  <= 16'd0;
    end else if (start) begin
      word_cnt_q  <= 8'd0;
      burst_cnt_q <= 20'd0;
      beat_cnt_q  <= 48'd0;
      repl_cnt_q  <= 16'd0;
      resp_cnt_q  <= 16'd0;
      last_cnt_q  <= 16'd0;
    end else if (p_valid_q) begin
      word_cnt_q <= p_last_q ? 8'd0 : word_cnt_q + 8'd1;
      beat_cnt_q <= beat_cnt_q + 48'd1;
      if (p_last_q)            burst_cnt_q <= burst_cnt_q + 20'd1;
      if (err_type[0]) repl_cnt_q <= sat_inc16(repl_cnt_q);
      if (err_type[1]) resp_cnt_q <= sat_inc16(resp_cnt_q);
      if (err_type[2]) last_cnt_q <= sat_inc16(last_cnt_q);
    end
  end

`ifdef RD_CHECK_ERR_CAPTURE_EN
  logic [15:0]     p_rid_q, p_lane0_q;
  logic            cap_valid_q;
  logic [CapW-1:0] cap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_rid_q     <= 16'd0;
      p_lane0_q   <= 16'd0;
      cap_valid_q <= 1'b0;
      cap_q       <= '0;
    end else if (start) begin
      p_rid_q     <= 16'd0;
      p_lane0_q   <= 16'd0;
      cap_valid_q <= 1'b0;
      cap_q       <= '0;
    end else begin
      if (take) begin
        p_rid_q   <= rid_m;
        p_lane0_q <= rdata_m[15:0];
      end
      if ((err_type != 3'b000) && !cap_valid_q) begin
        cap_valid_q <= 1'b1;
        cap_q       <= {p_rid_q, err_type, word_cnt_q, p_lane0_q};
      end
    end
  end

  assign cap_rd = {{(64 - CapW){1'b0}}, cap_q};
`else
  logic unused_rid;
  assign unused_rid = ^rid_m;
  assign cap_rd     = 64'd0;
`endif

  always_comb begin
    case (softreg_req_addr)
      ADDR_CTRL:   rd_data = {state_q, 54'd0, exp_len_q};
      ADDR_BEATS:  rd_data = {16'd0, beat_cnt_q};
      ADDR_BURSTS: rd_data = {44'd0, burst_cnt_q};
      ADDR_ERRS:   rd_data = {repl_cnt_q, resp_cnt_q, last_cnt_q, 16'd0};
      ADDR_CAP:    rd_data = cap_rd;
      default:     rd_data = 64'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= 64'd0;
    end else begin
      resp_valid_q <= softreg_req_valid && !softreg_req_isWrite;
      if (softreg_req_valid && !softreg_req_isWrite) resp_data_q <= rd_data;
    end
  end

  assign softreg_resp_valid = resp_valid_q;
  assign softreg_resp_data  = resp_data_q;
  assign chk_done           = (state_q == StDone);
  assign chk_err            = (repl_cnt_q != 16'd0) || (resp_cnt_q != 16'd0) ||
                              (last_cnt_q != 16'd0);

endmodule

// File: tb/tb_rd_check.sv
// Scoreboard bench for rd_check: softreg reads push expected data, a monitor pops on response.
module tb_rd_check;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  rid_m;
  logic [511:0] rdata_m;
  logic [1:0]   rresp_m;
  logic         rlast_m, rvalid_m, rready_m;
  logic         softreg_req_valid, softreg_req_isWrite;
  logic [31:0]  softreg_req_addr;
  logic [63:0]  softreg_req_data;
  logic         softreg_resp_valid;
  logic [63:0]  softreg_resp_data;
  logic         chk_done, chk_err;

  rd_check dut (
    .clk                 (clk),
    .rst                 (rst),
    .rid_m               (rid_m),
    .rdata_m             (rdata_m),
    .rresp_m             (rresp_m),
    .rlast_m             (rlast_m),
    .rvalid_m            (rvalid_m),
    .rready_m            (rready_m),
    .softreg_req_valid   (softreg_req_valid),
    .softreg_req_isWrite (softreg_req_isWrite),
    .softreg_req_addr    (softreg_req_addr),
    .softreg_req_data    (softreg_req_data),
    .softreg_resp_valid  (softreg_resp_valid),
    .softreg_resp_data   (softreg_resp_data),
    .chk_done            (chk_done),
    .chk_err             (chk_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (softreg_resp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got %h expected no response", softreg_resp_data);
      end else begin
        e = sb_q.pop_front();
        check(e.name, softreg_resp_data, e.data);
      end
    end
  end

  function automatic logic [63:0] ctrl(input int len, input int tgt);
    logic [31:0] l, t;
    l = len;
    t = tgt;
    return {36'd0, t[19:0], l[7:0]};
  endfunction

  // All tasks enter and leave on a falling edge.
  task automatic sw_write(input logic [31:0] addr, input logic [63:0] data);
    softreg_req_valid   = 1'b1;
    softreg_req_isWrite = 1'b1;
    softreg_req_addr    = addr;
    softreg_req_data    = data;
    @(negedge clk);
    softreg_req_valid   = 1'b0;
    softreg_req_isWrite = 1'b0;
  endtask

  task automatic sw_read(input logic [31:0] addr, input logic [63:0] exp, input string name);
    exp_t e;
    e.data = exp;
    e.name = name;
    sb_q.push_back(e);
    softreg_req_valid   = 1'b1;
    softreg_req_isWrite = 1'b0;
    softreg_req_addr    = addr;
    @(negedge clk);
    softreg_req_valid   = 1'b0;
  endtask

  task automatic beat(input logic [511:0] data, input logic [1:0] resp, input logic last,
                      input logic [15:0] rid);
    rvalid_m = 1'b1;
    rready_m = 1'b1;
    rdata_m  = data;
    rresp_m  = resp;
    rlast_m  = last;
    rid_m    = rid;
    @(negedge clk);
    rvalid_m = 1'b0;
    rready_m = 1'b0;
    rlast_m  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [511:0] good, lane5, lane1;
  logic [63:0]  cap_exp;

  initial begin
    good  = {32{16'hA5A5}};
    lane5 = 512'd1 << 80;
    lane1 = 512'd1 << 16;
    rst = 1'b1;
    rid_m = '0; rdata_m = '0; rresp_m = '0; rlast_m = 1'b0; rvalid_m = 1'b0; rready_m = 1'b0;
    softreg_req_valid = 1'b0; softreg_req_isWrite = 1'b0;
    softreg_req_addr = '0; softreg_req_data = '0;
    idle(3);
    rst = 1'b0;
    idle(1);

    // Reset state
    check("rst_done", {63'd0, chk_done}, 64'd0);
    check("rst_err", {63'd0, chk_err}, 64'd0);
    sw_read(32'h60, 64'd0, "rst_ctrl");
    sw_read(32'h68, 64'd0, "rst_beats");
    sw_read(32'h78, 64'd0, "rst_errs");

    // Clean run: exp_len 3, target 2, 8 beats with one non-ready stall
    sw_write(32'h60, ctrl(3, 2));
    for (int i = 1; i <= 8; i++) begin
      beat(good, 2'b00, (i == 4) || (i == 8), 16'd7);
      if (i == 2) begin
        rvalid_m = 1'b1;
        @(negedge clk);
        rvalid_m = 1'b0;
      end
    end
    idle(3);
    sw_read(32'h68, 64'd8, "clean_beats");
    sw_read(32'h70, 64'd2, "clean_bursts");
    sw_read(32'h78, 64'd0, "clean_errs");
    sw_read(32'h60, 64'h8000_0000_0000_0003, "clean_ctrl");
    sw_read(32'h64, 64'd0, "unmapped");
    check("clean_done", {63'd0, chk_done}, 64'd1);
    check("clean_err", {63'd0, chk_err}, 64'd0);

    // Replication error on lane 5
    sw_write(32'h60, ctrl(0, 1));
    beat(lane5, 2'b00, 1'b1, 16'h1234);
    idle(3);
    sw_read(32'h78, 64'h0001_0000_0000_0000, "repl_errs");
`ifdef RD_CHECK_ERR_CAPTURE_EN
    cap_exp = {21'd0, 16'h1234, 3'b001, 8'd0, 16'h0000};
`else
    cap_exp = 64'd0;
`endif
    sw_read(32'h80, cap_exp, "repl_cap");
    check("repl_done", {63'd0, chk_done}, 64'd1);
    check("repl_err", {63'd0, chk_err}, 64'd1);

    // Early rlast then SLVERR
    sw_write(32'h60, ctrl(1, 5));
    beat(good, 2'b00, 1'b1, 16'h00AB);
    beat(good, 2'b10, 1'b0, 16'h00AC);
    idle(3);
    sw_read(32'h78, 64'h0000_0001_0001_0000, "last_resp_errs");
    sw_read(32'h60, 64'h4000_0000_0000_0001, "last_resp_ctrl");
    sw_read(32'h70, 64'd1, "last_resp_bursts");
`ifdef RD_CHECK_ERR_CAPTURE_EN
    cap_exp = {21'd0, 16'h00AB, 3'b100, 8'd0, 16'hA5A5};
`else
    cap_exp = 64'd0;
`endif
    sw_read(32'h80, cap_exp, "last_cap");
    check("last_resp_done", {63'd0, chk_done}, 64'd0);

    // Reset aborts a run
    sw_write(32'h60, ctrl(7, 1));
    for (int i = 0; i < 3; i++) beat(good, 2'b00, 1'b0, 16'd1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    sw_read(32'h60, 64'd0, "abort_ctrl");
    sw_read(32'h68, 64'd0, "abort_beats");
    for (int i = 0; i < 5; i++) beat(good, 2'b00, 1'b0, 16'd1);
    idle(2);
    sw_read(32'h68, 64'd0, "abort_idle_beats");
    check("abort_err", {63'd0, chk_err}, 64'd0);

    // Start coinciding with a beat
    sw_write(32'h60, ctrl(0, 20'hFFFFF));
    beat(good, 2'b00, 1'b1, 16'd2);
    beat(good, 2'b00, 1'b1, 16'd2);
    softreg_req_valid = 1'b1; softreg_req_isWrite = 1'b1;
    softreg_req_addr = 32'h60; softreg_req_data = ctrl(0, 20'hFFFFF);
    rvalid_m = 1'b1; rready_m = 1'b1; rlast_m = 1'b1; rdata_m = good;
    @(negedge clk);
    softreg_req_valid = 1'b0; softreg_req_isWrite = 1'b0;
    rvalid_m = 1'b0; rready_m = 1'b0; rlast_m = 1'b0;
    sw_read(32'h68, 64'd0, "start_beat_cnt");
    idle(2);
    sw_read(32'h68, 64'd0, "start_beat_cnt_late");
    sw_read(32'h70, 64'd0, "start_burst_cnt");

    // Saturation of the replication error counter
    sw_write(32'h60, ctrl(0, 20'hFFFFF));
    for (int i = 0; i < 70000; i++) beat(lane1, 2'b00, 1'b1, 16'd3);
    idle(3);
    sw_read(32'h78, 64'hFFFF_0000_0000_0000, "sat_errs");
    sw_read(32'h68, 64'd70000, "sat_beats");
    sw_read(32'h70, 64'd70000, "sat_bursts");
    check("sat_err", {63'd0, chk_err}, 64'd1);

    idle(4);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rd_check.md
RD_CHECK -- requirements
Module: rd_check

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have ports rid_m (16), rdata_m (512), rresp_m (2), rlast_m (1), rvalid_m (1), rready_m (1), all inputs: passive monitor of the AXI read-data channel.
REQ-004 SHALL have ports softreg_req_valid (1), softreg_req_isWrite (1), softreg_req_addr (32), softreg_req_data (64), all inputs: softreg request.
REQ-005 SHALL have ports softreg_resp_valid (1) and softreg_resp_data (64), outputs: softreg response.
REQ-006 SHALL have ports chk_done (1) and chk_err (1), outputs: run complete and any error seen.

Function
REQ-007 SHALL define a beat as a cycle with rvalid_m && rready_m.
REQ-008 SHALL use states IDLE, RUN and DONE.
REQ-009 Softreg write to 0x60 SHALL latch exp_len = data[7:0] and target = data[27:8].
REQ-010 The same write SHALL clear all counters and capture registers and enter RUN from any state.
REQ-011 Beats in IDLE or DONE SHALL be ignored.
REQ-012 In RUN, each beat SHALL be registered into one pipeline stage. Counters and errors SHALL update exactly 1 cycle after the beat.
REQ-013 Replication error: any 16-bit lane of rdata_m differs from lane 0.
REQ-014 Response error: rresp_m != 2'b00.
REQ-015 Last error: rlast_m is asserted with word_cnt != exp_len, or is deasserted with word_cnt == exp_len.
REQ-016 word_cnt (8 bit) SHALL increment per beat and reset to 0 on a beat with rlast_m.
REQ-017 burst_cnt (20 bit) SHALL increment on each beat with rlast_m.
REQ-018 beat_cnt SHALL be 48 bits, wrapping.
REQ-019 Each of the three error counters SHALL be 16 bits and saturate at 0xFFFF.
REQ-020 RUN SHALL go to DONE in the cycle after the pipelined burst_cnt equals target. target = 0 SHALL go to DONE after 1 burst.
REQ-021 A start write coinciding with a beat SHALL take priority; that beat is not counted.
REQ-022 chk_done SHALL be 1 exactly in DONE. chk_err SHALL be 1 when any error counter is nonzero.
REQ-023 Softreg read SHALL set softreg_resp_valid 1 cycle later with registered data:
- 0x60: {state[1:0] at 63:62, zeros, exp_len[7:0]}
- 0x68: beat_cnt
- 0x70: burst_cnt
- 0x78: {repl_err, resp_err, last_err, 16'd0}
- 0x80: first-error capture
- other addresses: 0
REQ-024 rid_m SHALL be recorded only in the first-error capture.

Reset
REQ-025 On rst, asynchronously: state IDLE; all counters, pipeline and capture registers 0; softreg_resp_valid, chk_done, chk_err 0; exp_len and target 0.
REQ-026 rst asserted mid-RUN SHALL abort the run. No beat SHALL be counted until the next start write.

Configuration
REQ-027 With RD_CHECK_ERR_CAPTURE_EN defined, the first error SHALL capture {rid_m[15:0], error-type[2:0], word_cnt[7:0], lane0[15:0]} into 0x80, frozen until the next start.
REQ-028 Without RD_CHECK_ERR_CAPTURE_EN, no capture register SHALL exist and 0x80 SHALL read 0.

Structure
REQ-029 Package rd_check_pkg SHALL hold softreg address constants, the state enum and the error-type encoding (REPL=1, RESP=2, LAST=4).
REQ-030 Sub-module rd_check_lane_cmp SHALL compute the 512-bit lane-replication compare combinationally. Its result is registered in rd_check.

Verification
REQ-031 Start with exp_len=3, target=2; 8 beats of {32{16'hA5A5}}, OKAY, rlast on beats 4 and 8 -> beat_cnt=8, burst_cnt=2, chk_done=1, chk_err=0.
REQ-032 exp_len=0, target=1; 1 beat with lane 5 = 16'h0001 and other lanes 0 -> repl_err=1; capture (with macro) type=1, word_cnt=0.
REQ-033 exp_len=1; rlast on beat 1, then beat with rresp=2'b10 -> last_err=1, resp_err=1.
REQ-034 Assert rst for 1 cycle after 3 of 8 beats -> state IDLE, counters 0. Further beats -> beat_cnt stays 0.
REQ-035 Start write in the same cycle as a beat -> beat_cnt=0 one cycle later.
REQ-036 70000 replication errors -> repl_err=0xFFFF.
